// File: rtl/xalu_nibble_sequencer.sv
// Sequences one WIDTH-bit operation through an external 4-bit xalu slice, one nibble per clock,
// chaining carries/shift bits and adding the one's-complement end-around-carry pass.
module xalu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic                 com_mode,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 zero,
    output logic                 neg_zero,
    output logic                 equ,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_f,
    output logic                 alu_ci_right,
    output logic                 alu_ci_left,
    output logic                 alu_com,
    input  logic [3:0]           alu_d,
    input  logic                 alu_co_left,
    input  logic                 alu_co_right,
    input  logic                 alu_equ
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] K_LAST = IW'(NIBBLES - 1);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EAC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     k_q, k_d, nib;
    logic [2:0]        op_q, op_d;
    logic              com_q, com_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic              carry_q, carry_d, equ_acc_q, equ_acc_d;
    logic              busy_q, busy_d, done_q, done_d, cout_q, cout_d;
    logic              zero_q, zero_d, neg_zero_q, neg_zero_d, equ_q, equ_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            op_q       <= '0;
            com_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            equ_acc_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
            neg_zero_q <= 1'b0;
            equ_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            op_q       <= op_d;
            com_q      <= com_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            equ_acc_q  <= equ_acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cout_q     <= cout_d;
            zero_q     <= zero_d;
            neg_zero_q <= neg_zero_d;
            equ_q      <= equ_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        op_d         = op_q;
        com_d        = com_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        carry_d      = carry_q;
        equ_acc_d    = equ_acc_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cout_d       = cout_q;
        zero_d       = zero_q;
        neg_zero_d   = neg_zero_q;
        equ_d        = equ_q;
        alu_a        = 4'h0;
        alu_b        = 4'h0;
        alu_f        = 3'd0;
        alu_ci_right = 1'b0;
        alu_ci_left  = 1'b0;
        alu_com      = 1'b0;
        // SHR walks from the MSB nibble down so the shift-in bit enters at the top
        nib          = (op_q == OP_SHR) ? (K_LAST - k_q) : k_q;

        // busy covers the done cycle, then drops unless a new start is accepted
        if (done_q) busy_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    k_d       = '0;
                    op_d      = op;
                    com_d     = com_mode;
                    a_d       = op_a;
                    b_d       = op_b;
                    carry_d   = (op == OP_ADD || op == OP_SHR || op == OP_SHL) ? cin : 1'b0;
                    equ_acc_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_RUN: begin
                alu_a   = a_q[nib*4 +: 4];
                alu_b   = b_q[nib*4 +: 4];
                alu_f   = op_q;
                alu_com = com_q;
                case (op_q)
                    OP_ADD, OP_SHL: begin
                        alu_ci_right = carry_q;
                        carry_d      = alu_co_left;
                    end
                    OP_SHR: begin
                        alu_ci_left = carry_q;
                        carry_d     = alu_co_right;
                    end
                    default: carry_d = 1'b0;
                endcase
                result_d[nib*4 +: 4] = alu_d;
                equ_acc_d = equ_acc_q & alu_equ;
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (op_q == OP_ADD && com_q && carry_d) state_d = S_EAC;
                    else                                    state_d = S_DONE;
                end
            end
            S_EAC: begin
                alu_a        = result_q[k_q*4 +: 4];
                alu_f        = OP_ADD;
                alu_ci_right = carry_q;
                alu_com      = com_q;
                result_d[k_q*4 +: 4] = alu_d;
                carry_d = alu_co_left;
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d     = 1'b1;
                cout_d     = carry_q;
                zero_d     = (result_q == '0);
                neg_zero_d = &result_q;
                equ_d      = equ_acc_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign zero     = zero_q;
    assign neg_zero = neg_zero_q;
    assign equ      = equ_q;

endmodule

// File: tb/tb_xalu_nibble_sequencer.sv
// Directed bench for xalu_nibble_sequencer (NIBBLES=4) with a behavioural 4-bit slice model.
module tb_xalu_nibble_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, com_mode, cin;
    logic [2:0]  op;
    logic [15:0] op_a, op_b;
    logic        busy, done, cout, zero, neg_zero, equ;
    logic [15:0] result;
    logic [3:0]  alu_a, alu_b, alu_d;
    logic [2:0]  alu_f;
    logic        alu_ci_right, alu_ci_left, alu_com;
    logic        alu_co_left, alu_co_right, alu_equ;
    logic [4:0]  sum5;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    logic [3:0] first_a;
    logic [2:0] first_f;
    logic       first_busy;

    xalu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .com_mode(com_mode),
        .op_a(op_a), .op_b(op_b), .cin(cin), .busy(busy), .done(done),
        .result(result), .cout(cout), .zero(zero), .neg_zero(neg_zero), .equ(equ),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_ci_right(alu_ci_right),
        .alu_ci_left(alu_ci_left), .alu_com(alu_com), .alu_d(alu_d),
        .alu_co_left(alu_co_left), .alu_co_right(alu_co_right), .alu_equ(alu_equ)
    );

    always #5 clk = ~clk;

    // Slice: ADD carries right-to-left; shifts move one bit through the opposite carry pin.
    always_comb begin
        sum5         = 5'(alu_a) + 5'(alu_b) + 5'(alu_ci_right);
        alu_d        = 4'h0;
        alu_co_left  = 1'b0;
        alu_co_right = 1'b0;
        case (alu_f)
            3'd0: begin alu_d = sum5[3:0]; alu_co_left = sum5[4]; end
            3'd1: alu_d = alu_a & alu_b;
            3'd2: alu_d = alu_a | alu_b;
            3'd3: alu_d = alu_a ^ alu_b;
            3'd4: alu_d = alu_a;
            3'd5: alu_d = alu_b;
            3'd6: begin alu_d = {alu_ci_left, alu_a[3:1]}; alu_co_right = alu_a[0]; end
            default: begin alu_d = {alu_a[2:0], alu_ci_right}; alu_co_left = alu_a[3]; end
        endcase
        alu_equ = (alu_a == alu_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request; lat counts edges from accept until done is seen.
    // With glitch set, a conflicting start is pulsed during RUN.
    task automatic run_op(input logic [2:0] f, input logic cm, input logic [15:0] a,
                          input logic [15:0] b, input logic ci, input bit glitch);
        @(negedge clk);
        start = 1'b1; op = f; com_mode = cm; op_a = a; op_b = b; cin = ci;
        @(posedge clk); #1;
        start = 1'b0;
        first_a = alu_a; first_f = alu_f; first_busy = busy;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (glitch && lat == 1) begin
                start = 1'b1; op = 3'd0; com_mode = 1'b0; op_a = 16'h0001; op_b = 16'h0002; cin = 1'b1;
            end
            if (lat == 2) start = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'd0; com_mode = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0;
        #23;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_alu_f", 32'(alu_f), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1: plain ADD with carries rippling through three nibbles
        run_op(3'd0, 1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        chk("t1_busy_accept", 32'(first_busy), 32'd1);
        chk("t1_first_a", 32'(first_a), 32'h4);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_result", 32'(result), 32'h2233);
        chk("t1_cout", 32'(cout), 32'd0);
        chk("t1_busy_done", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_result_hold", 32'(result), 32'h2233);
        chk("idle_alu_f", 32'(alu_f), 32'd0);

        // 2: wrap to zero with carry out
        run_op(3'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("t2_result", 32'(result), 32'h0000);
        chk("t2_cout", 32'(cout), 32'd1);
        chk("t2_zero", 32'(zero), 32'd1);
        chk("t2_neg_zero", 32'(neg_zero), 32'd0);
        chk("t2_equ", 32'(equ), 32'd0);

        // 3: one's-complement ADD needing the end-around-carry pass
        run_op(3'd0, 1'b1, 16'hFFFE, 16'h0003, 1'b0, 1'b0);
        chk("t3_latency", 32'(lat), 32'd9);
        chk("t3_result", 32'(result), 32'h0002);
        chk("t3_cout", 32'(cout), 32'd0);

        // 4: shifts in both directions
        run_op(3'd6, 1'b0, 16'h8421, 16'h0000, 1'b1, 1'b0);
        chk("t4_shr_first_a", 32'(first_a), 32'h8);
        chk("t4_shr_f", 32'(first_f), 32'd6);
        chk("t4_shr_result", 32'(result), 32'hC210);
        chk("t4_shr_cout", 32'(cout), 32'd1);
        run_op(3'd7, 1'b0, 16'h8421, 16'h0000, 1'b0, 1'b0);
        chk("t4_shl_result", 32'(result), 32'h0842);
        chk("t4_shl_cout", 32'(cout), 32'd1);

        // OR to all ones
        run_op(3'd2, 1'b0, 16'hF0F0, 16'h0F0F, 1'b1, 1'b0);
        chk("or_result", 32'(result), 32'hFFFF);
        chk("or_neg_zero", 32'(neg_zero), 32'd1);
        chk("or_zero", 32'(zero), 32'd0);
        chk("or_cout", 32'(cout), 32'd0);

        // 5: XOR of equal operands, with a stray start during RUN
        run_op(3'd3, 1'b0, 16'hA5A5, 16'hA5A5, 1'b1, 1'b1);
        chk("t5_latency", 32'(lat), 32'd5);
        chk("t5_result", 32'(result), 32'h0000);
        chk("t5_zero", 32'(zero), 32'd1);
        chk("t5_equ", 32'(equ), 32'd1);
        chk("t5_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        chk("t5_no_restart", 32'(busy), 32'd0);

        // 6: reset while RUN is at k=2
        @(negedge clk);
        start = 1'b1; op = 3'd0; com_mode = 1'b0; op_a = 16'h1111; op_b = 16'h1111; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_result", 32'(result), 32'h0);
        chk("t6_zero", 32'(zero), 32'd0);
        chk("t6_equ", 32'(equ), 32'd0);
        chk("t6_alu_f", 32'(alu_f), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(3'd0, 1'b0, 16'h0005, 16'h0003, 1'b0, 1'b0);
        chk("t6_post_latency", 32'(lat), 32'd5);
        chk("t6_post_result", 32'(result), 32'h0008);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
